// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared trellis constants, metric types and the codeword helper
// for the rate-1/2, K=3 (g0=111, g1=101) Viterbi decoder.
package viterbi_pkg;
  localparam int NUM_STATES = 4;
  localparam int BM_W = 2;
  localparam int PM_W_DEF = 8;
  typedef logic [PM_W_DEF-1:0] pm_t;
  typedef logic [NUM_STATES-1:0][BM_W-1:0] bm_vec_t;
  function automatic logic [1:0] codeword(input logic [1:0] s, input logic u);
    return {u ^ s[1] ^ s[0], u ^ s[0]};
  endfunction
endpackage

// File: rtl/acs_butterfly.sv
// acs_butterfly: add-compare-select for one next state; candidates are summed at
// PM_W+1 bits and clamped to the all-ones metric before the compare.
module acs_butterfly import viterbi_pkg::*; #(
  parameter int PM_W = PM_W_DEF
) (
  input  logic [PM_W-1:0] pm_a_i,
  input  logic [PM_W-1:0] pm_b_i,
  input  logic [BM_W-1:0] bm_a_i,
  input  logic [BM_W-1:0] bm_b_i,
  output logic [PM_W-1:0] pm_o,
  output logic            dec_o
);
  logic [PM_W:0]   sum_a, sum_b;
  logic [PM_W-1:0] cand_a, cand_b;
  always_comb begin
    sum_a  = {1'b0, pm_a_i} + (PM_W+1)'(bm_a_i);
    sum_b  = {1'b0, pm_b_i} + (PM_W+1)'(bm_b_i);
    cand_a = sum_a[PM_W] ? '1 : sum_a[PM_W-1:0];
    cand_b = sum_b[PM_W] ? '1 : sum_b[PM_W-1:0];
    dec_o  = cand_b < cand_a;
    pm_o   = dec_o ? cand_b : cand_a;
  end
endmodule

// File: rtl/acs_path_metric_unit.sv
// acs_path_metric_unit: ACS and path-metric storage for the 4-state Viterbi trellis.
// Define ACS_PM_NORM_EN to enable MSB normalization; otherwise metrics saturate.
module acs_path_metric_unit import viterbi_pkg::*; #(
  parameter int PM_W      = PM_W_DEF,
  parameter int INIT_HIGH = 64,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         init,
  input  logic                         bm_valid,
  input  logic [NUM_STATES*BM_W-1:0]   bm,
  output logic                         dec_valid,
  output logic [NUM_STATES-1:0]        dec,
  output logic [1:0]                   best_state,
  output logic [PM_W-1:0]              best_metric,
  output logic [NUM_STATES*PM_W-1:0]   pm_flat,
  output logic [CNT_W-1:0]             sym_cnt
);
  bm_vec_t               bmv;
  logic [PM_W-1:0]       pm_q [NUM_STATES];
  logic [PM_W-1:0]       acs  [NUM_STATES];
  logic [PM_W-1:0]       pm_d [NUM_STATES];
  logic [NUM_STATES-1:0] dec_d, dec_q;
  logic                  norm, dec_valid_q;
  logic [1:0]            best_state_d, best_state_q;
  logic [PM_W-1:0]       best_metric_d, best_metric_q;
  logic [CNT_W-1:0]      sym_cnt_q;
  assign bmv = bm;
  // Next state {u,n0} is reached from {n0,0} (pa) and {n0,1} (pb).
  for (genvar g = 0; g < NUM_STATES; g++) begin : g_acs
    localparam logic [1:0] PA = 2'((g % 2) * 2);
    localparam logic [1:0] PB = PA | 2'd1;
    localparam logic       U  = 1'(g / 2);
    acs_butterfly #(.PM_W(PM_W)) u_bf (
      .pm_a_i(pm_q[PA]),
      .pm_b_i(pm_q[PB]),
      .bm_a_i(bmv[codeword(PA, U)]),
      .bm_b_i(bmv[codeword(PB, U)]),
      .pm_o  (acs[g]),
      .dec_o (dec_d[g])
    );
    assign pm_d[g] = norm ? {1'b0, acs[g][PM_W-2:0]} : acs[g];
    assign pm_flat[g*PM_W +: PM_W] = pm_q[g];
  end
`ifdef ACS_PM_NORM_EN
  assign norm = acs[0][PM_W-1] & acs[1][PM_W-1] & acs[2][PM_W-1] & acs[3][PM_W-1];
`else
  assign norm = 1'b0;
`endif
  always_comb begin
    best_state_d  = '0;
    best_metric_d = pm_d[0];
    for (int i = 1; i < NUM_STATES; i++)
      if (pm_d[i] < best_metric_d) begin
        best_state_d  = 2'(i);
        best_metric_d = pm_d[i];
      end
  end
  always_ff @(posedge clk) begin
    if (rst || init) begin
      for (int i = 0; i < NUM_STATES; i++) pm_q[i] <= (i == 0) ? '0 : PM_W'(INIT_HIGH);
      dec_q         <= '0;
      dec_valid_q   <= 1'b0;
      best_state_q  <= '0;
      best_metric_q <= '0;
      sym_cnt_q     <= '0;
    end else begin
      dec_valid_q <= bm_valid;
      if (bm_valid) begin
        pm_q          <= pm_d;
        dec_q         <= dec_d;
        best_state_q  <= best_state_d;
        best_metric_q <= best_metric_d;
        sym_cnt_q     <= sym_cnt_q + CNT_W'(1);
      end
    end
  end
  assign dec_valid   = dec_valid_q;
  assign dec         = dec_q;
  assign best_state  = best_state_q;
  assign best_metric = best_metric_q;
  assign sym_cnt     = sym_cnt_q;
endmodule

// File: tb/tb_acs_path_metric_unit.sv
// tb_acs_path_metric_unit: directed vectors plus a long all-3 branch-metric stream
// checked against an independent trellis model (normalizing or saturating per build).
module tb_acs_path_metric_unit;
  localparam int PM_W = 8, INIT_HIGH = 64, CNT_W = 16;
  logic clk = 1'b0, rst = 1'b1, init = 1'b0, bm_valid = 1'b0;
  logic [7:0] bm = '0;
  logic dec_valid;
  logic [3:0] dec;
  logic [1:0] best_state;
  logic [PM_W-1:0] best_metric;
  logic [4*PM_W-1:0] pm_flat;
  logic [CNT_W-1:0] sym_cnt;
  int checks = 0, failures = 0;
  int mp[4], gold[4];
  logic [3:0] mdec;

  always #5 clk = ~clk;

  acs_path_metric_unit #(.PM_W(PM_W), .INIT_HIGH(INIT_HIGH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .init(init), .bm_valid(bm_valid), .bm(bm),
    .dec_valid(dec_valid), .dec(dec), .best_state(best_state),
    .best_metric(best_metric), .pm_flat(pm_flat), .sym_cnt(sym_cnt)
  );

  typedef struct {
    logic ini; logic vld; logic [7:0] bm;
    logic [31:0] pm; logic [3:0] dec; logic dv; logic [1:0] bs; logic [7:0] bmet; logic [15:0] cnt;
  } vec_t;
  vec_t v[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic ini, input logic vld, input logic [7:0] b);
    init = ini; bm_valid = vld; bm = b;
    @(posedge clk); #1;
  endtask

  function automatic int cw(int s, int u);
    return (((u ^ (s >> 1) ^ s) & 1) << 1) | ((u ^ s) & 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mp[i] = (i == 0) ? 0 : INIT_HIGH;
      gold[i] = mp[i];
    end
  endtask

  task automatic model_step(input logic [7:0] b);
    int np[4], ng[4];
    bit all_hi = 1;
    for (int n = 0; n < 4; n++) begin
      int u = n >> 1, pa = (n & 1) * 2, pb = (n & 1) * 2 + 1;
      int ba = int'(b[2*cw(pa, u) +: 2]), bb = int'(b[2*cw(pb, u) +: 2]);
      int ca = mp[pa] + ba, cb = mp[pb] + bb;
      ca = (ca > 255) ? 255 : ca;
      cb = (cb > 255) ? 255 : cb;
      mdec[n] = cb < ca;
      np[n] = (cb < ca) ? cb : ca;
      ng[n] = (gold[pb] + bb < gold[pa] + ba) ? gold[pb] + bb : gold[pa] + ba;
      if (np[n] < 128) all_hi = 0;
    end
`ifdef ACS_PM_NORM_EN
    if (all_hi) for (int n = 0; n < 4; n++) np[n] -= 128;
`endif
    mp = np;
    gold = ng;
  endtask

  task automatic check_model(input int k);
    logic [31:0] e;
    int bs = 0;
    for (int i = 0; i < 4; i++) begin
      e[8*i +: 8] = 8'(mp[i]);
      if (mp[i] < mp[bs]) bs = i;
    end
    chk($sformatf("stream pm[%0d]", k), 64'(pm_flat), 64'(e));
    chk($sformatf("stream dec[%0d]", k), 64'(dec), 64'(mdec));
    chk($sformatf("stream best_state[%0d]", k), 64'(best_state), 64'(bs));
    chk($sformatf("stream best_metric[%0d]", k), 64'(best_metric), 64'(mp[bs]));
    chk($sformatf("stream dv[%0d]", k), 64'(dec_valid), 64'(1));
    chk($sformatf("stream cnt[%0d]", k), 64'(sym_cnt), 64'(k));
`ifdef ACS_PM_NORM_EN
    for (int i = 1; i < 4; i++)
      chk($sformatf("stream diff%0d[%0d]", i, k),
          64'(int'(pm_flat[8*i +: 8]) - int'(pm_flat[7:0])), 64'(gold[i] - gold[0]));
`endif
  endtask

  initial begin
    logic [7:0] prev;
    bit seen_drop = 0;
    v[0]  = '{0, 0, 8'h00, 32'h40404000, 4'b0000, 0, 0, 8'd0, 16'd0};
    v[1]  = '{0, 1, 8'h94, 32'h41024100, 4'b0000, 1, 0, 8'd0, 16'd1};
    v[2]  = '{0, 0, 8'hFF, 32'h41024100, 4'b0000, 0, 0, 8'd0, 16'd1};
    v[3]  = '{0, 0, 8'h00, 32'h41024100, 4'b0000, 0, 0, 8'd0, 16'd1};
    v[4]  = '{0, 1, 8'hC9, 32'h04030201, 4'b0000, 1, 0, 8'd1, 16'd2};
    v[5]  = '{0, 1, 8'h03, 32'h03010302, 4'b0001, 1, 2, 8'd1, 16'd3};
    v[6]  = '{0, 1, 8'h36, 32'h02020403, 4'b0001, 1, 2, 8'd2, 16'd4};
    v[7]  = '{0, 1, 8'hCC, 32'h02040203, 4'b1100, 1, 1, 8'd2, 16'd5};
    v[8]  = '{1, 1, 8'hFF, 32'h40404000, 4'b0000, 0, 0, 8'd0, 16'd0};
    v[9]  = '{0, 1, 8'h00, 32'h40004000, 4'b0000, 1, 0, 8'd0, 16'd1};
    v[10] = '{0, 1, 8'h00, 32'h00000000, 4'b0000, 1, 0, 8'd0, 16'd2};
    v[11] = '{0, 1, 8'h00, 32'h00000000, 4'b0000, 1, 0, 8'd0, 16'd3};
    v[12] = '{1, 0, 8'h00, 32'h40404000, 4'b0000, 0, 0, 8'd0, 16'd0};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      step(v[i].ini, v[i].vld, v[i].bm);
      chk($sformatf("vec%0d pm", i), 64'(pm_flat), 64'(v[i].pm));
      chk($sformatf("vec%0d dec", i), 64'(dec), 64'(v[i].dec));
      chk($sformatf("vec%0d dec_valid", i), 64'(dec_valid), 64'(v[i].dv));
      chk($sformatf("vec%0d best_state", i), 64'(best_state), 64'(v[i].bs));
      chk($sformatf("vec%0d best_metric", i), 64'(best_metric), 64'(v[i].bmet));
      chk($sformatf("vec%0d sym_cnt", i), 64'(sym_cnt), 64'(v[i].cnt));
    end
    rst = 1'b1;
    step(0, 1, 8'hFF);
    rst = 1'b0;
    model_reset();
    prev = best_metric;
    for (int k = 1; k <= 100; k++) begin
      step(0, 1, 8'hFF);
      model_step(8'hFF);
      check_model(k);
      if (best_metric < prev) seen_drop = 1;
      prev = best_metric;
    end
`ifdef ACS_PM_NORM_EN
    chk("norm event seen", 64'(seen_drop), 64'(1));
`else
    chk("saturated pm", 64'(pm_flat), 64'(32'hFFFFFFFF));
    chk("no wrap", 64'(seen_drop), 64'(0));
`endif
    step(0, 0, 8'h00);
    chk("idle after stream dv", 64'(dec_valid), 64'(0));
    chk("idle after stream cnt", 64'(sym_cnt), 64'(100));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
